// File: rtl/ram_dq_pkg.sv
// Shared definitions for the parametrised single-port RAM controller:
// read-during-write mode codes, clear FSM states and a counter-width helper.
package ram_dq_pkg;

  localparam int RDW_READ_FIRST  = 32'sd0;
  localparam int RDW_WRITE_FIRST = 32'sd1;

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks the array once, one word per cycle, while busy is high.
// Runs after reset (optionally) or on a single-cycle clear request.
module ram_clear_seq
  import ram_dq_pkg::*;
#(
  parameter int NUMWORDS       = 16384,
  parameter int CNT_W          = 14,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  output logic             busy,
  output logic [CNT_W-1:0] clr_addr,
  output logic             clr_we
);

  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NUMWORDS - 1);
  localparam clr_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  clr_state_e       state_r;
  clr_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // state and clear-address registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RESET_STATE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // next state; a clear request while already clearing is ignored
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      READY: begin
        if (clear) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = READY;
        end
        cnt_nxt_s = '0;
      end
      CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = READY;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = CLEAR;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = READY;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign busy     = (state_r == CLEAR);
  assign clr_we   = (state_r == CLEAR);
  assign clr_addr = cnt_r;

endmodule

// File: rtl/ram_dq_ctrl.sv
// Parametrised single-port synchronous RAM with clear sequencer, selectable
// read-during-write behaviour, optional output register and read-valid tracking.
module ram_dq_ctrl
  import ram_dq_pkg::*;
#(
  parameter int WIDTH          = 2,
  parameter int WIDTHAD        = 14,
  parameter int NUMWORDS       = 16384,
  parameter int OUTDATA_REG    = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clock_en,
  input  logic               we,
  input  logic [WIDTHAD-1:0] address,
  input  logic [WIDTH-1:0]   data,
  input  logic               clear,
  output logic [WIDTH-1:0]   q,
  output logic               qvalid,
  output logic               busy
);

  localparam int          CNT_W       = (clog2(NUMWORDS) < 1) ? 1 : clog2(NUMWORDS);
  localparam logic [31:0] NW_U        = 32'(NUMWORDS);
  localparam bit          WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  logic [WIDTH-1:0] mem_r [NUMWORDS];

  logic             busy_s;
  logic             clr_we_s;
  logic [CNT_W-1:0] clr_addr_s;
  logic             acc_s;
  logic             in_range_s;
  logic [CNT_W-1:0] user_idx_s;
  logic             wr_en_s;
  logic [CNT_W-1:0] wr_idx_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [WIDTH-1:0] rd_data_s;
  logic             acc_r;
  logic [WIDTH-1:0] rd_r;

  ram_clear_seq #(
    .NUMWORDS       (NUMWORDS),
    .CNT_W          (CNT_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .busy     (busy_s),
    .clr_addr (clr_addr_s),
    .clr_we   (clr_we_s)
  );

  // array port arbitration and read-data selection; a clear request beats a user access
  always_comb begin
    in_range_s = (32'(address) < NW_U);
    user_idx_s = address[CNT_W-1:0];
    acc_s      = clock_en && !busy_s && !clear;
    if (busy_s) begin
      wr_en_s   = clr_we_s;
      wr_idx_s  = clr_addr_s;
      wr_data_s = '0;
    end else begin
      wr_en_s   = acc_s && we && in_range_s;
      wr_idx_s  = user_idx_s;
      wr_data_s = data;
    end
    if (!in_range_s) begin
      rd_data_s = '0;
    end else if (WRITE_FIRST && we) begin
      rd_data_s = data;
    end else begin
      rd_data_s = mem_r[user_idx_s];
    end
  end

  // storage array; deliberately untouched by reset
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_data_s;
    end
  end

  // read result captured at the sampling edge so Q holds between accesses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= 1'b0;
      rd_r  <= '0;
    end else begin
      acc_r <= acc_s;
      if (acc_s) begin
        rd_r <= rd_data_s;
      end
    end
  end

  if (OUTDATA_REG != 0) begin : g_oreg
    logic             qv_o_r;
    logic [WIDTH-1:0] q_o_r;

    // extra output stage; keeps draining while clock_en is low
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        qv_o_r <= 1'b0;
        q_o_r  <= '0;
      end else begin
        qv_o_r <= acc_r;
        if (acc_r) begin
          q_o_r <= rd_r;
        end
      end
    end

    assign q      = q_o_r;
    assign qvalid = qv_o_r;
  end else begin : g_noreg
    assign q      = rd_r;
    assign qvalid = acc_r;
  end

  assign busy = busy_s;

endmodule

// File: tb/tb_ram_dq_ctrl.sv
// Self-checking bench: three configurations driven by shared stimulus and checked
// every cycle against a word-array reference model, plus literal spot checks.
module tb_ram_dq_ctrl;

  // dut0: 16384 words, no out reg, read-first, clear on reset
  // dut1: 1000 words/10-bit addr, out reg, write-first, clear on reset
  // dut2: 64 words/6-bit addr, out reg, read-first, no clear on reset
  localparam int NW [3]  = '{16384, 1000, 64};
  localparam int AW [3]  = '{14, 10, 6};
  localparam int OR [3]  = '{0, 1, 1};
  localparam int RDW [3] = '{0, 1, 0};
  localparam int COR [3] = '{1, 1, 0};

  logic        clock;
  logic        reset_n;
  logic        clock_en;
  logic        we;
  logic [13:0] address;
  logic [1:0]  data;
  logic        clear;
  logic [1:0]  q_s [3];
  logic        qv_s [3];
  logic        bz_s [3];

  int checks = 0;
  int errors = 0;

  // reference model state
  int mem [3][16384];
  bit kn  [3][16384];
  int clr_left [3];
  bit e_qv [3];
  int e_q [3];
  bit e_qk [3];
  bit p_acc [3];
  int p_rd [3];
  bit p_rdk [3];

  ram_dq_ctrl #(.WIDTH(2), .WIDTHAD(14), .NUMWORDS(16384), .OUTDATA_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .clock_en(clock_en), .we(we), .address(address),
    .data(data), .clear(clear), .q(q_s[0]), .qvalid(qv_s[0]), .busy(bz_s[0]));

  ram_dq_ctrl #(.WIDTH(2), .WIDTHAD(10), .NUMWORDS(1000), .OUTDATA_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clock_en(clock_en), .we(we), .address(address[9:0]),
    .data(data), .clear(clear), .q(q_s[1]), .qvalid(qv_s[1]), .busy(bz_s[1]));

  ram_dq_ctrl #(.WIDTH(2), .WIDTHAD(6), .NUMWORDS(64), .OUTDATA_REG(1), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .clock_en(clock_en), .we(we), .address(address[5:0]),
    .data(data), .clear(clear), .q(q_s[2]), .qvalid(qv_s[2]), .busy(bz_s[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h", name, inst, act, exp);
    end
  endtask

  task automatic m_reset(input int i);
    clr_left[i] = (COR[i] != 0) ? NW[i] : 0;
    e_qv[i] = 1'b0; e_q[i] = 0; e_qk[i] = 1'b1;
    p_acc[i] = 1'b0; p_rd[i] = 0; p_rdk[i] = 1'b1;
  endtask

  task automatic m_step(input int i);
    int a, rd;
    bit acc, rdk;
    acc = 1'b0; rd = 0; rdk = 1'b1;
    if (clr_left[i] > 0) begin
      mem[i][NW[i] - clr_left[i]] = 0;
      kn[i][NW[i] - clr_left[i]] = 1'b1;
      clr_left[i]--;
    end else if (clear) begin
      clr_left[i] = NW[i];
    end else if (clock_en) begin
      acc = 1'b1;
      a = int'(address) % (1 << AW[i]);
      if (a >= NW[i]) begin
        rd = 0; rdk = 1'b1;
      end else if (RDW[i] != 0 && we) begin
        rd = int'(data); rdk = 1'b1;
      end else begin
        rd = mem[i][a]; rdk = kn[i][a];
      end
      if (we && a < NW[i]) begin
        mem[i][a] = int'(data);
        kn[i][a] = 1'b1;
      end
    end
    if (OR[i] == 0) begin
      e_qv[i] = acc;
      if (acc) begin e_q[i] = rd; e_qk[i] = rdk; end
    end else begin
      e_qv[i] = p_acc[i];
      if (p_acc[i]) begin e_q[i] = p_rd[i]; e_qk[i] = p_rdk[i]; end
      p_acc[i] = acc;
      if (acc) begin p_rd[i] = rd; p_rdk[i] = rdk; end
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) m_reset(i);
      else m_step(i);
    end
  end

  // per-cycle comparison against the model
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      chk("busy", i, 32'(bz_s[i]), 32'(clr_left[i] > 0));
      chk("qvalid", i, 32'(qv_s[i]), 32'(e_qv[i]));
      if (e_qk[i]) chk("q", i, 32'(q_s[i]), 32'(e_q[i]));
    end
  end

  task automatic step(input bit ce, input bit w, input int a, input int d, input bit clr);
    @(posedge clock); #1;
    clock_en = ce; we = w; address = 14'(a); data = 2'(d); clear = clr;
  endtask

  // one access; returns dut0 result (no out reg) and dut1 result (one cycle later)
  task automatic probe(input bit w, input int a, input int d,
                       output int qa, output int qva, output int qb, output int qvb);
    step(1'b1, w, a, d, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clock); qa = int'(q_s[0]); qva = int'(qv_s[0]);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clock); qb = int'(q_s[1]); qvb = int'(qv_s[1]);
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (bz_s[0] === 1'b1 && n < 20000) begin
      n++;
      @(negedge clock);
    end
    chk(name, 0, 32'(n), 32'd16384);
  endtask

  initial begin
    int qa, qva, qb, qvb, n, base;
    int rd_addrs [3] = '{0, 8191, 16383};
    reset_n = 1'b0; clock_en = 1'b0; we = 1'b0; address = '0; data = '0; clear = 1'b0;
    for (int i = 0; i < 3; i++) m_reset(i);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_q", 0, 32'(q_s[0]), 32'd0);
    chk("rst_qvalid", 0, 32'(qv_s[0]), 32'd0);
    chk("rst_busy", 0, 32'(bz_s[0]), 32'd1);
    chk("rst_busy", 2, 32'(bz_s[2]), 32'd0);
    @(posedge clock); #1; reset_n = 1'b1;
    count_busy("clear_len");

    foreach (rd_addrs[k]) begin
      probe(1'b0, rd_addrs[k], 0, qa, qva, qb, qvb);
      chk("cleared_q", 0, 32'(qa), 32'd0);
      chk("cleared_qvalid", 0, 32'(qva), 32'd1);
    end

    probe(1'b1, 'h123, 2, qa, qva, qb, qvb);
    probe(1'b0, 'h123, 0, qa, qva, qb, qvb);
    chk("wr_rd_q", 0, 32'(qa), 32'd2);
    chk("wr_rd_qvalid", 0, 32'(qva), 32'd1);
    chk("wr_rd_q", 1, 32'(qb), 32'd2);
    chk("wr_rd_qvalid", 1, 32'(qvb), 32'd1);

    probe(1'b1, 'h40, 1, qa, qva, qb, qvb);
    probe(1'b1, 'h40, 3, qa, qva, qb, qvb);
    chk("rdw_read_first", 0, 32'(qa), 32'd1);
    chk("rdw_write_first", 1, 32'(qb), 32'd3);

    probe(1'b1, 999, 1, qa, qva, qb, qvb);
    probe(1'b1, 1000, 3, qa, qva, qb, qvb);
    chk("oor_q", 1, 32'(qb), 32'd0);
    chk("oor_qvalid", 1, 32'(qvb), 32'd1);
    probe(1'b0, 999, 0, qa, qva, qb, qvb);
    chk("oor_neighbour", 1, 32'(qb), 32'd1);
    probe(1'b0, 1000, 0, qa, qva, qb, qvb);
    chk("inrange_1000", 0, 32'(qa), 32'd3);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i, 3, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    n = 0;
    while (n < 17000) begin
      @(posedge clock); #1;
      if (bz_s[0] !== 1'b1) begin
        clock_en = 1'b0; we = 1'b0; clear = 1'b0;
        break;
      end
      clock_en = 1'b1; we = 1'b1; address = 14'($urandom_range(0, 15)); data = 2'd3; clear = 1'b0;
      n++;
    end
    chk("clear_done", 0, 32'(n < 17000), 32'd1);
    for (int i = 0; i < 16; i++) begin
      probe(1'b0, i, 0, qa, qva, qb, qvb);
      chk("after_clear", 0, 32'(qa), 32'd0);
    end

    step(1'b0, 1'b0, 0, 0, 1'b1);
    repeat (100) step(1'b0, 1'b0, 0, 0, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1; reset_n = 1'b1;
    count_busy("restart_len");

    repeat (3000) begin
      case ($urandom_range(0, 2))
        0: base = 0;
        1: base = 990;
        default: base = 16370;
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           base + int'($urandom_range(0, 13)), int'($urandom_range(0, 3)), 1'b0);
    end
    step(1'b0, 1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dq_ctrl.md
Name: ram_dq_ctrl

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 16Kx2 single-port RAM.
- Generic width and depth. Optional output register. Selectable read-during-write mode.
- Built-in clear sequencer zeroes the array after reset or on request.
- Data-valid tracking of the read pipeline, so downstream lab logic needs no hand-counted latency.

Parameters:
- WIDTH, 2, data word width in bits (1..32)
- WIDTHAD, 14, address width in bits
- NUMWORDS, 16384, number of implemented words (must be <= 2**WIDTHAD)
- OUTDATA_REG, 0, 0 = unregistered read data, 1 = extra output register stage
- RDW_MODE, 0, read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data)
- CLEAR_ON_RESET, 1, 1 = run clear sequence automatically after Reset deasserts

Ports:
- Clock  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- ClockEn  in  1  access enable; no access is sampled while low
- WE  in  1  write enable, qualified by ClockEn
- Address  in  WIDTHAD  word address, sampled at Clock when ClockEn=1
- Data  in  WIDTH  write data, sampled with Address
- Clear  in  1  single-cycle request to zero the whole array
- Q  out  WIDTH  read data
- QValid  out  1  Q holds the result of a sampled access
- Busy  out  1  clear sequence running; user accesses are ignored

Behaviour:
- Reset low, asynchronous: all control and pipeline registers go to 0.
  - Q=0, QValid=0.
  - Busy=CLEAR_ON_RESET; the FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - The array contents are not touched by reset itself.
- FSM states are READY and CLEAR.
  - READY -> CLEAR on Clear=1.
  - CLEAR -> READY after writing address NUMWORDS-1.
  - Clear asserted while in CLEAR is ignored.
- CLEAR state:
  - Internal counter 0..NUMWORDS-1 writes zero to one word per cycle, regardless of ClockEn.
  - Busy=1 for exactly NUMWORDS cycles.
  - QValid=0 throughout.
  - Busy falls on the edge after the last write. The first user access is accepted in the following cycle.
- Reset asserted mid-clear: the sequence aborts immediately. After release it restarts from 0 if CLEAR_ON_RESET=1; otherwise the array is left partly cleared.
- Access in READY: Address, Data and WE are registered at a rising edge with ClockEn=1.
  - Write: if WE=1, the array is written at that same edge.
  - Read: every sampled access (read or write) produces a read result.
- Latency from the sampling edge:
  - OUTDATA_REG=0: Q and QValid update at that edge; Q appears combinationally from the registered address.
  - OUTDATA_REG=1: Q and QValid update one edge later.
- QValid pulses high for one cycle per sampled access and is 0 in cycles with no access. Q holds its last value when QValid=0.
- Read-during-write (same access):
  - RDW_MODE=0: Q returns the pre-write content.
  - RDW_MODE=1: Q returns Data.
- Address >= NUMWORDS: the write is dropped, the read returns 0, and QValid still asserts.
- ClockEn=0 holds all input registers. The output register (if present) still drains its pending QValid.
- Clear and ClockEn in the same cycle in READY: Clear wins and the access is dropped.

Decomposition:
- Package ram_dq_pkg: RDW_READ_FIRST/RDW_WRITE_FIRST constants, the FSM state enum (READY, CLEAR), and a clog2 helper for the counter width.
- One sub-module, ram_clear_seq: FSM plus address counter. It outputs Busy, clear address and clear write strobe, which the top level muxes onto the array port.
- The array itself is an inferred register array in the top level, with no vendor primitive.

Test Plan (WIDTH=2, WIDTHAD=14, NUMWORDS=16384 unless stated):
1. Release Reset with CLEAR_ON_RESET=1 -> Busy=1 for exactly 16384 cycles; a subsequent read of addresses 0, 8191 and 16383 returns Q=2'b00 with QValid=1.
2. Write 2'b10 @0x0123, then read @0x0123 -> Q=2'b10; QValid=1 in the same cycle (OUTDATA_REG=0) and one cycle later (OUTDATA_REG=1).
3. @0x0040 holds 2'b01; write 2'b11 @0x0040 -> Q=2'b01 with RDW_MODE=0, Q=2'b11 with RDW_MODE=1.
4. Pulse Clear after filling 0x0000-0x000F with 2'b11; also drive ClockEn=1/WE=1 during Busy -> those writes are ignored; after Busy falls, all words read back 2'b00.
5. Assert Reset at clear count 100, release 3 cycles later -> Busy stays high and the counter restarts at 0; Busy falls after a full 16384 cycles.
6. NUMWORDS=1000, WIDTHAD=10: write 2'b11 @1000 then read @1000 -> Q=2'b00, QValid=1; word 999 is unchanged.
